// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Requester identifiers
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    // Latency counter width and the legal LATENCY range it supports
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 15;

    function automatic logic lat_ok(input int unsigned lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// 4-bit loadable down-counter timing the memory read latency.
module mem_lat_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load takes priority over decrement; the count never wraps below 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Expiry flag for the controlling FSM
    always_comb begin
        zero = (cnt == '0);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the
// instruction-fetch and data paths, one transaction in flight at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 2
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic              ifGnt,
    output logic              ifValid,
    output logic [DATA_W-1:0] ifRdata,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    output logic              dGnt,
    output logic              dValid,
    output logic [DATA_W-1:0] dRdata,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata
);

    generate
        if (!lat_ok(LATENCY)) begin : g_lat_range
            $error("mem_arbiter: LATENCY must be within 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

    state_t state;
    logic   last_served;
    logic   id_q;
    logic   we_q;
    logic   any_req;
    logic   pick;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_zero;

    // Round-robin choice: a lone request wins, a tie goes to the one not served last
    always_comb begin
        any_req = ifReq | dReq;
        pick    = REQ_IF;
        if (ifReq && dReq) begin
            pick = (last_served == REQ_IF) ? REQ_D : REQ_IF;
        end else if (dReq) begin
            pick = REQ_D;
        end
    end

    // Counter is loaded in ISSUE so it already holds LATENCY-1 in the first WAIT cycle
    always_comb begin
        cnt_load = (state == ISSUE) && !we_q;
        cnt_dec  = (state == WAIT) && !cnt_zero;
    end

    mem_lat_counter u_lat_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (LAT_LOAD),
        .zero     (cnt_zero)
    );

    // Transaction FSM with registered handshake, memory and read-data outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_served <= REQ_D;
            id_q        <= REQ_IF;
            we_q        <= 1'b0;
            ifGnt       <= 1'b0;
            dGnt        <= 1'b0;
            ifValid     <= 1'b0;
            dValid      <= 1'b0;
            memEn       <= 1'b0;
            memWe       <= 1'b0;
            memAddr     <= '0;
            memWdata    <= '0;
            ifRdata     <= '0;
            dRdata      <= '0;
        end else begin
            ifGnt   <= 1'b0;
            dGnt    <= 1'b0;
            ifValid <= 1'b0;
            dValid  <= 1'b0;
            memEn   <= 1'b0;
            memWe   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state       <= ISSUE;
                        id_q        <= pick;
                        last_served <= pick;
                        we_q        <= (pick == REQ_D) && dWe;
                        memAddr     <= (pick == REQ_D) ? dAddr : ifAddr;
                        memWdata    <= (pick == REQ_D) ? dWdata : '0;
                        memEn       <= 1'b1;
                        memWe       <= (pick == REQ_D) && dWe;
                        ifGnt       <= (pick == REQ_IF);
                        dGnt        <= (pick == REQ_D);
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        state   <= RESP;
                        ifValid <= (id_q == REQ_IF);
                        dValid  <= (id_q == REQ_D);
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_zero) begin
                        state <= RESP;
                        if (id_q == REQ_IF) begin
                            ifRdata <= memRdata;
                            ifValid <= 1'b1;
                        end else begin
                            dRdata <= memRdata;
                            dValid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
